moving_average_ctrl: RTL and testbench

- Sequencing FSM for the 32-tap moving-average datapath in the VGA audio path.
- On each audio sample tick it runs one full update of the datapath: clear flags, load the new sample, shift the window, accumulate, publish. It issues one strobe at a time and waits on the matching done flag.
- Also handles initial clear, a software re-init, a per-step watchdog and sample-overrun detection.

---
 rtl/moving_average_ctrl_pkg.sv | 25 ++
 rtl/moving_average_ctrl_watchdog.sv | 30 +++
 rtl/moving_average_ctrl.sv | 122 ++++++++++++
 tb/tb_moving_average_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moving_average_ctrl_pkg.sv
// Shared definitions for the moving-average controller and its datapath.
// Holds the sequencer state encoding and the window/accumulate geometry.
package moving_average_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RSIG,
    LOAD,
    SHIFT,
    MULT,
    SEND,
    DONE
  } state_t;

  localparam int TAPS        = 32;
  localparam int SHIFT_NUM   = 5;
  localparam int MULT_CYCLES = 33;

  // States in which the sequencer is waiting on a datapath done flag.
  function automatic logic is_wait(input state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/moving_average_ctrl_watchdog.sv
// Per-step watchdog: counts cycles spent waiting, clears on state entry.
// expire is combinational from the count; no backpressure.
module moving_average_ctrl_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Fires on the cycle whose edge would bring the count to TIMEOUT.
  assign expire = en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequencer for the 32-tap moving-average datapath: one strobe at a time, each held until its done flag.
// Sample-to-result latency 39 cycles minimum; ticks arriving while busy are dropped and flagged as overrun.
module moving_average_ctrl
  import moving_average_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             reinit,
  output logic             ld_values,
  output logic             rsignals,
  output logic             ld_newsample,
  output logic             shift,
  output logic             multiply,
  output logic             send,
  input  logic             loaddone,
  input  logic             rsignalsdone,
  input  logic             newsampleloaded,
  input  logic             shiftdone,
  input  logic             multiplydone,
  input  logic             sentdone,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun,
  output logic             error,
  output logic [CNT_W-1:0] update_count
);

  state_t state_q, state_d;
  logic   flag;
  logic   wd_en, wd_clr, wd_expire;

  assign wd_en  = is_wait(state_q) && !flag;
  assign wd_clr = reinit || wd_expire || (state_d != state_q);

  moving_average_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      error        <= 1'b0;
      overrun      <= 1'b0;
      update_count <= '0;
    end else begin
      state_q <= state_d;
      error   <= wd_expire && !reinit;
      if (reinit) begin
        overrun <= 1'b0;
      end else if (sample_tick && busy) begin
        overrun <= 1'b1;
      end
      if (state_q == DONE) begin
        update_count <= update_count + 1'b1;
      end
    end
  end

  always_comb begin
    flag         = 1'b0;
    state_d      = state_q;
    ld_values    = 1'b0;
    rsignals     = 1'b0;
    ld_newsample = 1'b0;
    shift        = 1'b0;
    multiply     = 1'b0;
    send         = 1'b0;
    result_valid = 1'b0;

    // Only the flag owned by the current step is looked at.
    case (state_q)
      INIT:    flag = loaddone;
      RSIG:    flag = rsignalsdone;
      LOAD:    flag = newsampleloaded;
      SHIFT:   flag = shiftdone;
      MULT:    flag = multiplydone;
      SEND:    flag = sentdone;
      default: flag = 1'b0;
    endcase

    if (reinit || wd_expire) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT:    if (flag) state_d = IDLE;
        IDLE:    if (sample_tick) state_d = RSIG;
        RSIG:    if (flag) state_d = LOAD;
        LOAD:    if (flag) state_d = SHIFT;
        SHIFT:   if (flag) state_d = MULT;
        MULT:    if (flag) state_d = SEND;
        SEND:    if (flag) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = INIT;
      endcase
    end

    // Strobes are decoded from the state register but forced low while reset is held.
    if (!reset) begin
      case (state_q)
        INIT:    ld_values    = 1'b1;
        RSIG:    rsignals     = 1'b1;
        LOAD:    ld_newsample = 1'b1;
        SHIFT:   shift        = 1'b1;
        MULT:    multiply     = 1'b1;
        SEND:    send         = 1'b1;
        default: ;
      endcase
    end
    result_valid = (state_q == DONE);
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Bench for moving_average_ctrl: behavioural datapath, phase-level reference model, per-cycle compare.
module tb_moving_average_ctrl;
  import moving_average_ctrl_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 5;
  localparam int MULT_P  = 4;                       // phase index of first MULT cycle (RSIG = 1)
  localparam int SEND_P  = MULT_P + MULT_CYCLES;    // 37
  localparam int RES_P   = SEND_P + 1;              // 38

  logic clk = 1'b0;
  logic reset, sample_tick, reinit, stall;
  logic [15:0] sample_in;
  logic ld_values, rsignals, ld_newsample, shift, multiply, send;
  logic loaddone, rsignalsdone, newsampleloaded, shiftdone, multiplydone, sentdone;
  logic result_valid, busy, overrun, error;
  logic [CNT_W-1:0] update_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  moving_average_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .reinit(reinit),
    .ld_values(ld_values), .rsignals(rsignals), .ld_newsample(ld_newsample),
    .shift(shift), .multiply(multiply), .send(send),
    .loaddone(loaddone), .rsignalsdone(rsignalsdone), .newsampleloaded(newsampleloaded),
    .shiftdone(shiftdone), .multiplydone(multiplydone), .sentdone(sentdone),
    .result_valid(result_valid), .busy(busy), .overrun(overrun), .error(error),
    .update_count(update_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- datapath model: sticky flags, 32-sample window ----------------
  logic ld_q, rs_q, nl_q, sh_q, md_q, sd_q;
  int mcnt, acc, dout;
  logic [15:0] latched;
  int win [TAPS];

  function automatic int win_sum();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += win[i];
    return s;
  endfunction

  assign loaddone        = ld_q | ld_values;
  assign rsignalsdone    = rs_q | rsignals;
  assign newsampleloaded = nl_q | ld_newsample;
  assign shiftdone       = sh_q | shift;
  assign multiplydone    = md_q | (multiply && (mcnt == MULT_CYCLES - 1) && !stall);
  assign sentdone        = sd_q | send;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {ld_q, rs_q, nl_q, sh_q, md_q, sd_q} <= '0;
      mcnt <= 0; acc <= 0; dout <= 0; latched <= '0;
      for (int i = 0; i < TAPS; i++) win[i] <= 0;
    end else begin
      if (ld_values) begin
        for (int i = 0; i < TAPS; i++) win[i] <= 0;
        ld_q <= 1'b1;
      end
      if (rsignals) begin
        {ld_q, nl_q, sh_q, md_q, sd_q} <= '0;
        rs_q <= 1'b1;
        mcnt <= 0;
      end
      if (ld_newsample) begin
        latched <= sample_in;
        nl_q <= 1'b1;
        rs_q <= 1'b0;
      end
      if (shift) begin
        for (int i = TAPS - 1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= int'(latched);
        sh_q <= 1'b1;
      end
      if (multiply) begin
        mcnt <= mcnt + 1;
        if (multiplydone) begin
          acc <= win_sum();
          md_q <= 1'b1;
        end
      end
      if (send) begin
        dout <= acc >> SHIFT_NUM;
        sd_q <= 1'b1;
      end
    end
  end

  // ---------------- reference model: idle / init / update phase counter ----------------
  localparam int M_INIT = 0, M_IDLE = 1, M_UPD = 2;
  int m_mode, m_p;
  logic m_err, m_ovr;
  logic [CNT_W-1:0] m_cnt;
  int mq [$];

  function automatic logic m_rv();
    return (m_mode == M_UPD) && (m_p == RES_P) && !stall;
  endfunction

  function automatic logic [5:0] m_strobes();
    if (m_mode == M_INIT) return 6'b100000;
    if (m_mode != M_UPD) return 6'b000000;
    if (m_p == 1) return 6'b010000;
    if (m_p == 2) return 6'b001000;
    if (m_p == 3) return 6'b000100;
    if (m_p >= MULT_P && (m_p < SEND_P || stall)) return 6'b000010;
    if (m_p == SEND_P) return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic int m_avg();
    int s = 0;
    foreach (mq[i]) s += mq[i];
    return s >> SHIFT_NUM;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= M_INIT; m_p <= 0; m_err <= 1'b0; m_ovr <= 1'b0; m_cnt <= '0;
      mq.delete();
    end else begin
      m_err <= 1'b0;
      if (m_rv()) m_cnt <= m_cnt + 1'b1;
      if (reinit) begin
        m_mode <= M_INIT;
        m_ovr <= 1'b0;
        mq.delete();
      end else begin
        if (sample_tick && m_mode != M_IDLE) m_ovr <= 1'b1;
        case (m_mode)
          M_INIT: m_mode <= M_IDLE;
          M_IDLE: if (sample_tick) begin
            m_mode <= M_UPD;
            m_p <= 1;
            mq.push_back(int'(sample_in));
            if (mq.size() > TAPS) void'(mq.pop_front());
          end
          default: begin
            if (stall && m_p == MULT_P + TIMEOUT - 1) begin
              m_mode <= M_INIT;
              m_err <= 1'b1;
              mq.delete();
            end else if (!stall && m_p == RES_P) begin
              m_mode <= M_IDLE;
            end else begin
              m_p <= m_p + 1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [5:0] strobes;
  assign strobes = {ld_values, rsignals, ld_newsample, shift, multiply, send};

  always @(negedge clk) begin
    if (!reset) begin
      chk("strobes_onehot", 32'($onehot0(strobes)), 1);
      chk("strobes", strobes, m_strobes());
      chk("busy", busy, (m_mode != M_IDLE));
      chk("result_valid", result_valid, m_rv());
      chk("overrun", overrun, m_ovr);
      chk("error", error, m_err);
      chk("update_count", update_count, m_cnt);
      if (m_rv()) chk("avg_out", dout, m_avg());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input logic [15:0] v);
    sample_in = v;
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return result_valid;
      1: return multiply;
      2: return shift;
      default: return error;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input int limit, input string nm, output int waited);
    waited = 0;
    while (!sig(sel) && waited < limit) begin
      cyc(1);
      waited++;
    end
    if (!sig(sel)) chk({nm, "_seen"}, 0, 1);
  endtask

  int w, n;

  initial begin
    reset = 1'b1; sample_tick = 1'b0; reinit = 1'b0; stall = 1'b0; sample_in = '0;
    #3;
    chk("rst_strobes", strobes, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_count", update_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);

    // Single sample of 32: latency counted from tick cycle through result cycle inclusive.
    tick(16'd32);
    wait_hi(0, 100, "first_valid", w);
    chk("first_latency", w + 2, 39);
    chk("first_avg", dout, 1);
    cyc(1);
    chk("first_count", update_count, 1);

    // Fill the window with 64s; count wraps at 2^CNT_W.
    cyc(10);
    for (int i = 0; i < 32; i++) begin
      tick(16'd64);
      cyc(49);
    end
    chk("fill_avg", dout, 64);
    chk("fill_count", update_count, 33 % (1 << CNT_W));
    chk("fill_overrun", overrun, 0);

    // Tick dropped mid-update.
    tick(16'd100);
    cyc(9);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    n = 0;
    repeat (60) begin
      cyc(1);
      if (result_valid) n++;
    end
    chk("ovr_results", n, 1);
    chk("ovr_sticky", overrun, 1);

    // reinit during MULT discards the update.
    tick(16'd7);
    wait_hi(1, 20, "reinit_mult", w);
    cyc(5);
    reinit = 1'b1;
    cyc(1);
    reinit = 1'b0;
    chk("reinit_ld_values", ld_values, 1);
    chk("reinit_overrun", overrun, 0);
    chk("reinit_count", update_count, 34 % (1 << CNT_W));
    n = 0;
    repeat (60) begin
      cyc(1);
      if (result_valid) n++;
    end
    chk("reinit_results", n, 0);

    // Watchdog: multiplydone never arrives.
    stall = 1'b1;
    tick(16'd5);
    wait_hi(1, 20, "wd_mult", w);
    wait_hi(3, 400, "wd_error", w);
    chk("wd_latency", w, 255);
    chk("wd_ld_values", ld_values, 1);
    stall = 1'b0;
    cyc(5);

    // Asynchronous reset mid-SHIFT.
    tick(16'd9);
    wait_hi(2, 20, "rst_shift", w);
    #2 reset = 1'b1;
    #1 chk("async_rst_strobes", strobes, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_init", ld_values, 1);
    cyc(2);

    // Randomized ticks and occasional reinit.
    for (int i = 0; i < 4000; i++) begin
      sample_tick = ($urandom_range(0, 39) == 0);
      reinit = ($urandom_range(0, 299) == 0);
      if (sample_tick && m_mode == M_IDLE) sample_in = 16'($urandom_range(0, 65535));
      cyc(1);
    end
    sample_tick = 1'b0;
    reinit = 1'b0;
    cyc(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
